// File: rtl/violation_control.sv
// Violation supervisor: per-source saturating counters, sticky flags, a windowed
// event counter and a NOMINAL/WARN/FAULT/HOLDOFF state machine with a clear handshake.
module violation_control #(
  parameter int SRC_N = 11,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SRC_N-1:0]         violations_i,
  input  logic [SRC_N-1:0]         mask_i,
  input  logic [SRC_N-1:0]         fatal_en_i,
  input  logic [CNT_W-1:0]         fault_threshold_i,
  input  logic [TMR_W-1:0]         window_len_i,
  input  logic [TMR_W-1:0]         holdoff_len_i,
  input  logic                     clear_req_i,
  output logic                     clear_ack_o,
  input  logic [$clog2(SRC_N)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]         rd_data_o,
  output logic [SRC_N-1:0]         sticky_o,
  output logic [1:0]               state_o,
  output logic                     warn_o,
  output logic                     fault_o,
  output logic                     recovery_clear_o,
  output logic                     generation_pause_o
);

  localparam int SEL_W = $clog2(SRC_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    NOMINAL = 2'd0,
    WARN    = 2'd1,
    FAULT   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t state, state_next;

  logic             armed;
  logic             in_holdoff, accept, win_wrap, hold_last, fatal_hit, thr_hit;
  logic [SRC_N-1:0] events;
  logic [TMR_W-1:0] win_tmr, hold_tmr, win_len, hold_len;
  logic [CNT_W-1:0] win_cnt, win_cnt_next, rd_next;
  logic [CNT_W-1:0] cnt [SRC_N];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    sat_add = (s > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  function automatic int unsigned popcount(input logic [SRC_N-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SRC_N; i++) n = n + 32'(v[i]);
    popcount = n;
  endfunction

  assign in_holdoff = (state == HOLDOFF);
  // armed drops on acceptance and only re-arms once the request has been seen low
  assign accept     = clear_req_i && armed && ((state == WARN) || (state == FAULT));
  assign events     = (in_holdoff || accept) ? '0 : (violations_i & ~mask_i);

  assign win_len   = (window_len_i == '0) ? TMR_W'(1) : window_len_i;
  assign hold_len  = (holdoff_len_i == '0) ? TMR_W'(1) : holdoff_len_i;
  assign win_wrap  = (win_tmr >= win_len - TMR_W'(1));
  assign hold_last = (hold_tmr >= hold_len - TMR_W'(1));

  assign win_cnt_next = sat_add(win_wrap ? '0 : win_cnt, popcount(events));
  assign fatal_hit    = |(events & fatal_en_i);
  assign thr_hit      = (fault_threshold_i != '0) && (win_cnt_next >= fault_threshold_i);

  always_comb begin
    state_next = state;
    case (state)
      NOMINAL: begin
        if (fatal_hit || thr_hit) state_next = FAULT;
        else if (|events)         state_next = WARN;
      end
      WARN: begin
        if (accept)                    state_next = NOMINAL;
        else if (fatal_hit || thr_hit) state_next = FAULT;
      end
      FAULT:   if (accept)    state_next = HOLDOFF;
      HOLDOFF: if (hold_last) state_next = NOMINAL;
      default: state_next = NOMINAL;
    endcase
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < SRC_N; i++)
      if (rd_sel_i == SEL_W'(i)) rd_next = cnt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NOMINAL;
      armed       <= 1'b1;
      clear_ack_o <= 1'b0;
      rd_data_o   <= '0;
      sticky_o    <= '0;
      win_cnt     <= '0;
      win_tmr     <= '0;
      hold_tmr    <= '0;
      for (int i = 0; i < SRC_N; i++) cnt[i] <= '0;
    end else begin
      state       <= state_next;
      clear_ack_o <= accept;
      rd_data_o   <= rd_next;
      if (accept)            armed <= 1'b0;
      else if (!clear_req_i) armed <= 1'b1;
      hold_tmr <= (in_holdoff && !hold_last) ? hold_tmr + TMR_W'(1) : '0;
      if (accept) begin
        sticky_o <= '0;
        win_cnt  <= '0;
        win_tmr  <= '0;
        for (int i = 0; i < SRC_N; i++) cnt[i] <= '0;
      end else begin
        sticky_o <= sticky_o | events;
        win_cnt  <= win_cnt_next;
        win_tmr  <= win_wrap ? '0 : win_tmr + TMR_W'(1);
        for (int i = 0; i < SRC_N; i++)
          if (violations_i[i] && !in_holdoff) cnt[i] <= sat_add(cnt[i], 1);
      end
    end
  end

  assign state_o            = state;
  assign warn_o             = (state == WARN);
  assign fault_o            = (state == FAULT);
  assign recovery_clear_o   = (state == FAULT) || (state == HOLDOFF);
  assign generation_pause_o = (state == FAULT);

endmodule

// File: tb/tb_violation_control.sv
// Bench for violation_control: vector table for the clear handshake plus
// hand-written sequences for fatal, windowed threshold, holdoff, saturation and reset.
module tb_violation_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] violations_i = '0;
  logic [10:0] mask_i = '0;
  logic [10:0] fatal_en_i = '0;
  logic [7:0]  fault_threshold_i = '0;
  logic [15:0] window_len_i = 16'd10;
  logic [15:0] holdoff_len_i = 16'd5;
  logic        clear_req_i = 1'b0;
  logic        clear_ack_o;
  logic [3:0]  rd_sel_i = '0;
  logic [7:0]  rd_data_o;
  logic [10:0] sticky_o;
  logic [1:0]  state_o;
  logic        warn_o, fault_o, recovery_clear_o, generation_pause_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rd_q[$];

  typedef struct {
    logic [10:0] viol;
    logic        clr;
    logic [1:0]  st;
    logic [10:0] sticky;
    logic        ack;
  } vec_t;
  vec_t vecs[14];

  violation_control dut (
    .clk(clk), .rst(rst),
    .violations_i(violations_i), .mask_i(mask_i), .fatal_en_i(fatal_en_i),
    .fault_threshold_i(fault_threshold_i), .window_len_i(window_len_i),
    .holdoff_len_i(holdoff_len_i), .clear_req_i(clear_req_i), .clear_ack_o(clear_ack_o),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .sticky_o(sticky_o), .state_o(state_o),
    .warn_o(warn_o), .fault_o(fault_o), .recovery_clear_o(recovery_clear_o),
    .generation_pause_o(generation_pause_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("rd_data", 32'(rd_data_o), 32'(e));
    end
  endtask

  task automatic read_cnt(input logic [3:0] sel, input logic [7:0] exp);
    rd_sel_i = sel;
    violations_i = '0;
    clear_req_i = 1'b0;
    rd_q.push_back(exp);
    tick();
  endtask

  task automatic set_cfg(input logic [10:0] m, input logic [10:0] f, input logic [7:0] thr,
                         input logic [15:0] win, input logic [15:0] hold);
    mask_i = m; fatal_en_i = f; fault_threshold_i = thr; window_len_i = win; holdoff_len_i = hold;
  endtask

  task automatic do_reset();
    violations_i = '0; clear_req_i = 1'b0; rd_sel_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Rows: masked pulse, warn, clear, held request, re-arm, pending request.
    vecs[0]  = '{11'h001, 1'b0, 2'd0, 11'h000, 1'b0};
    vecs[1]  = '{11'h004, 1'b0, 2'd1, 11'h004, 1'b0};
    vecs[2]  = '{11'h010, 1'b0, 2'd1, 11'h014, 1'b0};
    vecs[3]  = '{11'h000, 1'b1, 2'd0, 11'h000, 1'b1};
    vecs[4]  = '{11'h000, 1'b1, 2'd0, 11'h000, 1'b0};
    vecs[5]  = '{11'h020, 1'b1, 2'd1, 11'h020, 1'b0};
    vecs[6]  = '{11'h000, 1'b1, 2'd1, 11'h020, 1'b0};
    vecs[7]  = '{11'h000, 1'b0, 2'd1, 11'h020, 1'b0};
    vecs[8]  = '{11'h000, 1'b1, 2'd0, 11'h000, 1'b1};
    vecs[9]  = '{11'h000, 1'b0, 2'd0, 11'h000, 1'b0};
    vecs[10] = '{11'h000, 1'b1, 2'd0, 11'h000, 1'b0};
    vecs[11] = '{11'h040, 1'b1, 2'd1, 11'h040, 1'b0};
    vecs[12] = '{11'h000, 1'b1, 2'd0, 11'h000, 1'b1};
    vecs[13] = '{11'h000, 1'b0, 2'd0, 11'h000, 1'b0};

    // Reset state and single warning pulse
    set_cfg(11'h000, 11'h000, 8'd0, 16'd10, 16'd5);
    do_reset();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_sticky", 32'(sticky_o), 32'd0);
    chk("rst_ack", 32'(clear_ack_o), 32'd0);
    chk("rst_rd", 32'(rd_data_o), 32'd0);
    chk("rst_recov", 32'(recovery_clear_o), 32'd0);
    chk("rst_pause", 32'(generation_pause_o), 32'd0);
    violations_i = 11'h004;
    tick();
    chk("warn_state", 32'(state_o), 32'd1);
    chk("warn_sticky", 32'(sticky_o), 32'h004);
    chk("warn_flag", 32'(warn_o), 32'd1);
    read_cnt(4'd2, 8'd1);
    read_cnt(4'd3, 8'd0);
    read_cnt(4'd11, 8'd0);
    read_cnt(4'd15, 8'd0);

    // Vector table: clear handshake
    set_cfg(11'h001, 11'h000, 8'd0, 16'd10, 16'd5);
    do_reset();
    for (int k = 0; k < 14; k++) begin
      violations_i = vecs[k].viol;
      clear_req_i  = vecs[k].clr;
      tick();
      chk($sformatf("vec%0d_state", k), 32'(state_o), 32'(vecs[k].st));
      chk($sformatf("vec%0d_sticky", k), 32'(sticky_o), 32'(vecs[k].sticky));
      chk($sformatf("vec%0d_ack", k), 32'(clear_ack_o), 32'(vecs[k].ack));
    end

    // Fatal source, masked then unmasked
    set_cfg(11'h100, 11'h100, 8'd0, 16'd10, 16'd5);
    do_reset();
    violations_i = 11'h100;
    tick();
    chk("masked_fatal_state", 32'(state_o), 32'd0);
    chk("masked_fatal_sticky", 32'(sticky_o), 32'd0);
    mask_i = 11'h000;
    violations_i = 11'h101;
    tick();
    chk("fatal_state", 32'(state_o), 32'd2);
    chk("fatal_sticky", 32'(sticky_o), 32'h101);
    chk("fatal_recov", 32'(recovery_clear_o), 32'd1);
    chk("fatal_pause", 32'(generation_pause_o), 32'd1);
    chk("fatal_warn", 32'(warn_o), 32'd0);
    chk("fatal_fault", 32'(fault_o), 32'd1);

    // Windowed threshold: 0,4,8 faults; 0,4,12 spans a wrap
    set_cfg(11'h000, 11'h000, 8'd3, 16'd10, 16'd5);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      violations_i = (c == 0 || c == 4 || c == 8) ? 11'h002 : 11'h000;
      tick();
      if (c == 0) chk("win_a_c0", 32'(state_o), 32'd1);
      if (c == 7) chk("win_a_c7", 32'(state_o), 32'd1);
      if (c == 8) chk("win_a_c8", 32'(state_o), 32'd2);
    end
    do_reset();
    for (int c = 0; c < 15; c++) begin
      violations_i = (c == 0 || c == 4 || c == 12) ? 11'h002 : 11'h000;
      tick();
      if (c == 12) chk("win_b_c12", 32'(state_o), 32'd1);
      if (c == 14) chk("win_b_c14", 32'(state_o), 32'd1);
    end

    // FAULT -> clear -> 5 HOLDOFF cycles with events ignored -> NOMINAL
    set_cfg(11'h000, 11'h100, 8'd0, 16'd10, 16'd5);
    do_reset();
    violations_i = 11'h103;
    tick();
    violations_i = 11'h001;
    tick();
    chk("ho_pre_state", 32'(state_o), 32'd2);
    violations_i = 11'h000;
    clear_req_i = 1'b1;
    tick();
    chk("ho_state0", 32'(state_o), 32'd3);
    chk("ho_ack", 32'(clear_ack_o), 32'd1);
    chk("ho_recov", 32'(recovery_clear_o), 32'd1);
    chk("ho_pause", 32'(generation_pause_o), 32'd0);
    clear_req_i = 1'b0;
    violations_i = 11'h7FF;
    for (int h = 1; h < 5; h++) begin
      tick();
      chk($sformatf("ho_state%0d", h), 32'(state_o), 32'd3);
      if (h == 1) chk("ho_ack_one", 32'(clear_ack_o), 32'd0);
    end
    tick();
    chk("ho_exit_state", 32'(state_o), 32'd0);
    chk("ho_exit_sticky", 32'(sticky_o), 32'd0);
    read_cnt(4'd0, 8'd0);
    read_cnt(4'd1, 8'd0);
    read_cnt(4'd8, 8'd0);

    // Saturation and clear colliding with a violation
    set_cfg(11'h000, 11'h000, 8'd0, 16'd10, 16'd5);
    do_reset();
    violations_i = 11'h001;
    repeat (300) tick();
    read_cnt(4'd0, 8'd255);
    violations_i = 11'h001;
    clear_req_i = 1'b1;
    tick();
    chk("sat_clr_state", 32'(state_o), 32'd0);
    chk("sat_clr_sticky", 32'(sticky_o), 32'd0);
    chk("sat_clr_ack", 32'(clear_ack_o), 32'd1);
    read_cnt(4'd0, 8'd0);

    // Async reset mid-HOLDOFF and mid-handshake
    set_cfg(11'h000, 11'h100, 8'd0, 16'd10, 16'd20);
    do_reset();
    violations_i = 11'h101;
    tick();
    violations_i = 11'h001;
    tick();
    violations_i = 11'h000;
    rd_sel_i = 4'd0;
    clear_req_i = 1'b1;
    tick();
    chk("pre_rst_state", 32'(state_o), 32'd3);
    chk("pre_rst_ack", 32'(clear_ack_o), 32'd1);
    chk("pre_rst_rd", 32'(rd_data_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_ack", 32'(clear_ack_o), 32'd0);
    chk("arst_rd", 32'(rd_data_o), 32'd0);
    chk("arst_recov", 32'(recovery_clear_o), 32'd0);
    chk("arst_pause", 32'(generation_pause_o), 32'd0);
    chk("arst_sticky", 32'(sticky_o), 32'd0);
    chk("arst_fault", 32'(fault_o), 32'd0);
    clear_req_i = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/violation_control.md
VIOLATION_CONTROL -- requirements
Module: violation_control

Interface
REQ-001 SHALL have parameter SRC_N, default 11, the number of violation sources.
REQ-002 SHALL have parameter CNT_W, default 8, the width of each per-source counter and of the window counter.
REQ-003 SHALL have parameter TMR_W, default 16, the width of the window and holdoff timers.
REQ-004 SHALL have port sys_dom_i.clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port sys_dom_i.rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port violations_i, input, SRC_N bits: one-cycle violation pulses. Bit order: [3:0] bandpass hi-over/hi-under/lo-over/lo-under; [7:4] drift hi-pos/hi-neg/lo-pos/lo-neg; [8] excessive drift; [9] expected delta mismatch; [10] preemptive delta mismatch.
REQ-007 SHALL have port mask_i, input, SRC_N bits: 1 masks the source.
REQ-008 SHALL have port fatal_en_i, input, SRC_N bits: an unmasked event on a set bit forces FAULT.
REQ-009 SHALL have port fault_threshold_i, input, CNT_W bits: windowed-event fault threshold; 0 disables the threshold.
REQ-010 SHALL have port window_len_i, input, TMR_W bits: window length in cycles; 0 is treated as 1.
REQ-011 SHALL have port holdoff_len_i, input, TMR_W bits: HOLDOFF duration in cycles; 0 is treated as 1.
REQ-012 SHALL have ports clear_req_i (input, 1 bit: clear request level) and clear_ack_o (output, 1 bit: one-cycle acknowledge).
REQ-013 SHALL have ports rd_sel_i (input, clog2(SRC_N) bits: counter select) and rd_data_o (output, CNT_W bits: registered counter readback).
REQ-014 SHALL have ports sticky_o (output, SRC_N bits: sticky flags) and state_o (output, 2 bits: FSM state).
REQ-015 SHALL have ports warn_o (output, 1 bit: state==WARN) and fault_o (output, 1 bit: state==FAULT).
REQ-016 SHALL have port recovery_clear_o, output, 1 bit: level drive to the recovery clear_state_i; high in FAULT and HOLDOFF.
REQ-017 SHALL have port generation_pause_o, output, 1 bit: level drive to the generation pause_en_i; high in FAULT only.

Function
REQ-018 SHALL define the states NOMINAL=0, WARN=1, FAULT=2, HOLDOFF=3, with state_o registered.
REQ-019 SHALL define an unmasked event as violations_i & ~mask_i, sampled while the state is not HOLDOFF; events in HOLDOFF are ignored entirely.
REQ-020 SHALL increment per-source counter i for every violations_i[i] pulse, masked or not, outside HOLDOFF, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL set sticky_o[i] on an unmasked event i and keep it set until an accepted clear.
REQ-022 SHALL use a window timer that counts 0..max(window_len_i,1)-1 and then wraps; the window count adds popcount(unmasked events) per cycle, saturating.
REQ-023 SHALL, on the window-wrap cycle, load the window count with that cycle's popcount instead of accumulating.
REQ-024 SHALL transition NOMINAL->WARN on any unmasked event.
REQ-025 SHALL transition NOMINAL or WARN->FAULT when an unmasked event hits fatal_en_i, or when the next window count is >= fault_threshold_i with the threshold nonzero; FAULT takes priority over WARN in the same cycle.
REQ-026 SHALL accept a clear when clear_req_i is high and the state is WARN or FAULT; clear_ack_o is high on the following cycle for exactly one cycle.
REQ-027 SHALL, on an accepted clear, zero the sticky flags, per-source counters, window count and window timer, and discard events arriving in the same cycle.
REQ-028 SHALL, on an accepted clear, transition WARN->NOMINAL and FAULT->HOLDOFF.
REQ-029 SHALL not accept clear_req_i in NOMINAL or HOLDOFF: no ack, and the request stays pending until it is acceptable.
REQ-030 SHALL remain in HOLDOFF for max(holdoff_len_i,1) cycles and then enter NOMINAL.
REQ-031 SHALL NOT re-acknowledge a clear while clear_req_i is held high: a new acceptance requires clear_req_i to have been low for at least 1 cycle.
REQ-032 SHALL present rd_data_o as counter[rd_sel_i] registered with 1-cycle latency; rd_sel_i >= SRC_N returns 0.

Reset
REQ-033 SHALL, on sys_dom_i.rst, immediately enter NOMINAL and zero all counters, sticky flags, timers and outputs (clear_ack_o=0, recovery_clear_o=0, generation_pause_o=0, rd_data_o=0), including mid-HOLDOFF or mid-handshake.

Verification
REQ-034 SHALL verify: mask=0, threshold=0, a pulse on bit 2 -> next cycle state_o=1, sticky_o=0x004, and rd_sel=2 reads 1 one cycle later.
REQ-035 SHALL verify: fatal_en=0x100, a pulse on bit 8 -> state FAULT, recovery_clear_o=1 and generation_pause_o=1 on the next cycle.
REQ-036 SHALL verify: threshold=3, window=10, pulses at cycles 0, 4 and 8 -> FAULT; pulses at 0, 4 and 12 -> WARN only.
REQ-037 SHALL verify: in FAULT, a clear request with holdoff=5 -> ack for 1 cycle, 5 HOLDOFF cycles with events ignored, then NOMINAL with all counters at 0.
REQ-038 SHALL verify: 300 pulses on bit 0 with CNT_W=8 -> count reads 255; a clear in the same cycle as a violation -> count 0 and the violation discarded.
REQ-039 SHALL verify: reset asserted in HOLDOFF -> state_o=0 and all outputs 0 asynchronously.
